// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed-latency VDG fetches take priority, the Z80 is
// held off via cpu_wait, and a watchdog forces a CPU slot after CPU_MAX_WAIT losses.
module vram_arbiter #(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned CPU_MAX_WAIT = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vdg_req,
    input  logic [ADDR_W-1:0] vdg_addr,
    output logic [7:0]        vdg_data,
    output logic              vdg_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    output logic              vdg_drop,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_d,
    input  logic [7:0]        ram_q
);

    localparam int unsigned WAIT_W = $clog2(CPU_MAX_WAIT + 1);

    typedef enum logic [1:0] {TAG_NONE, TAG_VDG, TAG_CPU_RD, TAG_CPU_WR} tag_t;
    typedef enum logic [1:0] {IDLE, RD1, RD2, WR_ACK} cpu_state_t;

    tag_t              tag1;
    tag_t              tag2;
    cpu_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              cpu_elig;
    logic              grant_vdg;
    logic              grant_cpu;

    // Slot arbitration: VDG first unless the watchdog has expired
    always_comb begin
        cpu_elig  = cpu_req && (state == IDLE) && !cpu_ack;
        grant_vdg = vdg_req && (wait_cnt < WAIT_W'(CPU_MAX_WAIT));
        grant_cpu = cpu_elig && !grant_vdg;
    end

    assign cpu_wait = cpu_req & ~cpu_ack;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tag1      <= TAG_NONE;
            tag2      <= TAG_NONE;
            state     <= IDLE;
            wait_cnt  <= '0;
            ram_a     <= '0;
            ram_we    <= 1'b0;
            ram_d     <= 8'h00;
            vdg_data  <= 8'h00;
            vdg_valid <= 1'b0;
            cpu_rdata <= 8'h00;
            cpu_ack   <= 1'b0;
            vdg_drop  <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            vdg_valid <= 1'b0;
            cpu_ack   <= 1'b0;
            tag2      <= tag1;

            // Stage 1: launch the granted access
            if (grant_vdg) begin
                tag1  <= TAG_VDG;
                ram_a <= vdg_addr;
            end else if (grant_cpu) begin
                tag1   <= cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
                ram_a  <= cpu_addr;
                ram_we <= cpu_we;
                ram_d  <= cpu_wdata;
            end else begin
                tag1 <= TAG_NONE;
            end

            if (grant_cpu) begin
                wait_cnt <= '0;
            end else if (cpu_elig) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            // A VDG request losing to the CPU can only mean the watchdog fired
            if (grant_cpu && vdg_req) begin
                vdg_drop <= 1'b1;
            end

            // Stage 2: ram_q belongs to the slot launched two edges ago
            if (tag2 == TAG_VDG) begin
                vdg_data  <= ram_q;
                vdg_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        state   <= cpu_we ? WR_ACK : RD1;
                        cpu_ack <= cpu_we;
                    end
                end
                RD1:    state <= RD2;
                RD2: begin
                    state     <= IDLE;
                    cpu_rdata <= ram_q;
                    cpu_ack   <= 1'b1;
                end
                WR_ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous 8 KB VRAM.
module tb_vram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        vdg_req;
    logic [12:0] vdg_addr;
    logic [7:0]  vdg_data;
    logic        vdg_valid;
    logic        cpu_req;
    logic        cpu_we;
    logic [12:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_wait;
    logic        vdg_drop;
    logic [12:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q = 8'h00;

    logic [7:0]  mem [0:8191];
    int          tests  = 0;
    int          failed = 0;
    int          we_cnt = 0;
    int          we0;

    vram_arbiter #(.ADDR_W(13), .CPU_MAX_WAIT(4)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .vdg_req(vdg_req), .vdg_addr(vdg_addr), .vdg_data(vdg_data), .vdg_valid(vdg_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait), .vdg_drop(vdg_drop),
        .ram_a(ram_a), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous RAM, one-cycle read latency, read-before-write
    always @(posedge clk_sys) begin
        if (ram_we) begin
            mem[ram_a] <= ram_d;
            we_cnt     <= we_cnt + 1;
        end
        ram_q <= mem[ram_a];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[13'h1FFF] = 8'h00;
        mem[13'h0100] = 8'h11;
        mem[13'h0200] = 8'h22;
        reset = 1'b1; vdg_req = 1'b0; vdg_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 8'h00;

        // Reset state
        repeat (2) tick();
        chk("rst_ram_a", 16'(ram_a), 16'h0);
        chk("rst_ram_we", 16'(ram_we), 16'h0);
        chk("rst_ram_d", 16'(ram_d), 16'h0);
        chk("rst_vdg_data", 16'(vdg_data), 16'h0);
        chk("rst_vdg_valid", 16'(vdg_valid), 16'h0);
        chk("rst_cpu_rdata", 16'(cpu_rdata), 16'h0);
        chk("rst_cpu_ack", 16'(cpu_ack), 16'h0);
        chk("rst_vdg_drop", 16'(vdg_drop), 16'h0);
        reset = 1'b0;
        tick();

        // VDG fetches every third cycle, two-clock latency
        for (int i = 0; i < 6; i++) begin
            vdg_req = 1'b1; vdg_addr = 13'(i);
            tick();
            chk("vdg_ram_a", 16'(ram_a), 16'(i));
            chk("vdg_ram_we", 16'(ram_we), 16'h0);
            chk("vdg_valid_e0", 16'(vdg_valid), 16'h0);
            vdg_req = 1'b0;
            tick();
            chk("vdg_valid_e1", 16'(vdg_valid), 16'h0);
            tick();
            chk("vdg_valid_e2", 16'(vdg_valid), 16'h1);
            chk("vdg_data", 16'(vdg_data), 16'(8'(i) ^ 8'h5A));
            chk("vdg_cpu_wait", 16'(cpu_wait), 16'h0);
        end

        // CPU write 0x1FFF <- 0xA5
        we0 = we_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'hA5;
        #1;
        chk("wr_wait_pending", 16'(cpu_wait), 16'h1);
        tick();
        chk("wr_ram_we", 16'(ram_we), 16'h1);
        chk("wr_ram_a", 16'(ram_a), 16'h1FFF);
        chk("wr_ram_d", 16'(ram_d), 16'hA5);
        chk("wr_ack", 16'(cpu_ack), 16'h1);
        chk("wr_wait_ack", 16'(cpu_wait), 16'h0);
        cpu_req = 1'b0;
        tick();
        chk("wr_we_off", 16'(ram_we), 16'h0);
        chk("wr_ack_off", 16'(cpu_ack), 16'h0);

        // CPU read back, request held through the ack cycle
        cpu_req = 1'b1; cpu_we = 1'b0;
        tick();
        chk("rd_ram_a", 16'(ram_a), 16'h1FFF);
        chk("rd_ram_we", 16'(ram_we), 16'h0);
        chk("rd_ack_e0", 16'(cpu_ack), 16'h0);
        tick();
        chk("rd_ack_e1", 16'(cpu_ack), 16'h0);
        tick();
        chk("rd_ack_e2", 16'(cpu_ack), 16'h1);
        chk("rd_rdata", 16'(cpu_rdata), 16'hA5);
        chk("rd_wait_ack", 16'(cpu_wait), 16'h0);
        tick();
        chk("held_no_ack", 16'(cpu_ack), 16'h0);
        chk("held_no_we", 16'(ram_we), 16'h0);
        cpu_req = 1'b0;
        repeat (2) begin
            tick();
            chk("held_no_dup_ack", 16'(cpu_ack), 16'h0);
        end
        chk("wr_rd_we_pulses", 16'(we_cnt - we0), 16'h1);

        // Collision: VDG wins, CPU slips one cycle
        vdg_req = 1'b1; vdg_addr = 13'h0200;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0100;
        tick();
        chk("col_ram_a_vdg", 16'(ram_a), 16'h0200);
        chk("col_cpu_wait", 16'(cpu_wait), 16'h1);
        vdg_req = 1'b0;
        tick();
        chk("col_ram_a_cpu", 16'(ram_a), 16'h0100);
        chk("col_ram_we", 16'(ram_we), 16'h0);
        tick();
        chk("col_vdg_valid", 16'(vdg_valid), 16'h1);
        chk("col_vdg_data", 16'(vdg_data), 16'h22);
        chk("col_ack_early", 16'(cpu_ack), 16'h0);
        tick();
        chk("col_ack", 16'(cpu_ack), 16'h1);
        chk("col_rdata", 16'(cpu_rdata), 16'h11);
        chk("col_vdg_valid_off", 16'(vdg_valid), 16'h0);
        chk("col_no_drop", 16'(vdg_drop), 16'h0);
        cpu_req = 1'b0;
        repeat (2) tick();

        // Watchdog: continuous VDG requests starve a pending CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0300; cpu_wdata = 8'h3C;
        vdg_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            vdg_addr = 13'(16 + k);
            tick();
            if (k == 4) begin
                chk("wd_ram_we", 16'(ram_we), 16'h1);
                chk("wd_ram_a", 16'(ram_a), 16'h0300);
                chk("wd_ram_d", 16'(ram_d), 16'h3C);
                chk("wd_ack", 16'(cpu_ack), 16'h1);
                chk("wd_drop", 16'(vdg_drop), 16'h1);
                cpu_req = 1'b0;
            end else begin
                chk("wd_vdg_ram_a", 16'(ram_a), 16'(16 + k));
                chk("wd_vdg_we", 16'(ram_we), 16'h0);
                chk("wd_vdg_ack", 16'(cpu_ack), 16'h0);
            end
            chk("wd_valid", 16'(vdg_valid), (k >= 2 && k != 6) ? 16'h1 : 16'h0);
            if (k >= 2 && k != 6)
                chk("wd_data", 16'(vdg_data), 16'(8'(16 + k - 2) ^ 8'h5A));
        end
        vdg_req = 1'b0;
        repeat (3) tick();
        chk("wd_drop_sticky", 16'(vdg_drop), 16'h1);

        // Reset one cycle after a CPU read grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
        tick();
        chk("mr_grant_a", 16'(ram_a), 16'h0005);
        tick();
        reset = 1'b1;
        #1;
        chk("mr_ram_a", 16'(ram_a), 16'h0);
        chk("mr_vdg_data", 16'(vdg_data), 16'h0);
        chk("mr_cpu_rdata", 16'(cpu_rdata), 16'h0);
        chk("mr_vdg_drop", 16'(vdg_drop), 16'h0);
        chk("mr_cpu_ack", 16'(cpu_ack), 16'h0);
        tick();
        cpu_req = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            tick();
            chk("mr_no_ack", 16'(cpu_ack), 16'h0);
            chk("mr_no_valid", 16'(vdg_valid), 16'h0);
        end
        cpu_req = 1'b1;
        tick();
        tick();
        chk("mr_re_ack_e1", 16'(cpu_ack), 16'h0);
        tick();
        chk("mr_re_ack", 16'(cpu_ack), 16'h1);
        chk("mr_re_rdata", 16'(cpu_rdata), 16'h5F);
        cpu_req = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter shared between the MC6847 display fetch path and the Z80 CPU. Sits between the VDG/CPU request sides and the 8 KB VRAM (synchronous read, one-cycle latency) and issues one RAM access per `clk_sys` cycle. The VDG gets fixed-latency priority service; the CPU is held off through a wait handshake. A watchdog guarantees CPU progress if the VDG request rate is ever violated.

## Interface
Parameters:
- `ADDR_W`, 13: VRAM address width.
- `CPU_MAX_WAIT`, 4: consecutive cycles the CPU may lose arbitration before it is forced a slot.

Ports:
- `clk_sys`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `vdg_req`  in  1  one-cycle fetch request, expected at most once per 3 cycles (`clk_vdg_en` cadence).
- `vdg_addr`  in  ADDR_W  fetch address, valid with `vdg_req`.
- `vdg_data`  out  8  last fetched byte, held until the next fetch returns.
- `vdg_valid`  out  1  one-cycle pulse when `vdg_data` updates.
- `cpu_req`  in  1  level request, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req`.
- `cpu_addr`  in  ADDR_W  CPU address; stable while `cpu_req`.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data, valid while `cpu_ack` is high and held afterwards.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_wait`  out  1  high while `cpu_req` is pending and not yet acked (drives Z80 `nWAIT` inverted).
- `vdg_drop`  out  1  sticky: a VDG fetch was displaced by the watchdog; cleared only by reset.
- `ram_a`  out  ADDR_W  registered RAM address.
- `ram_we`  out  1  registered write strobe.
- `ram_d`  out  8  registered write data.
- `ram_q`  in  8  RAM read data, valid one cycle after `ram_a`.

## Operation
- Slot pipeline with two stages. Stage 1 tag ∈ {NONE, VDG, CPU_RD, CPU_WR} is registered together with `ram_a`/`ram_we`/`ram_d`. The stage 2 tag follows stage 1 by one cycle and marks the cycle `ram_q` is captured.
- Arbitration at each edge, in priority order:
  1. If `vdg_req` is high and `wait_cnt < CPU_MAX_WAIT`, grant VDG.
  2. Otherwise, if the CPU is eligible, grant CPU.
  3. Otherwise NONE.
- CPU eligibility: `cpu_req` is high and the CPU FSM is in IDLE.
- Watchdog: `wait_cnt` increments each edge the CPU is eligible but not granted, and clears on a CPU grant. When `wait_cnt == CPU_MAX_WAIT`, the CPU is granted even if `vdg_req` is high. That VDG request is discarded (no `vdg_valid`) and `vdg_drop` sets.
- CPU FSM:
  - IDLE → WR_ACK on a write grant.
  - IDLE → RD1 on a read grant.
  - RD1 → RD2.
  - RD2 → IDLE, capturing `ram_q` into `cpu_rdata` with `cpu_ack` = 1.
  - WR_ACK → IDLE.
  - Not eligible in any non-IDLE state, or in the cycle `cpu_ack` is high. The requester drops `cpu_req` at that edge, so a completed request is never re-granted.
- `cpu_wait` = `cpu_req` & ~`cpu_ack`, combinational.
- Back-to-back VDG requests on consecutive cycles are served on consecutive cycles (fully pipelined).
- Write-then-read to the same address by the CPU returns the new data (serialized through RAM, no bypass).

## Timing
- Reset values: `ram_a` = 0, `ram_we` = 0, `ram_d` = 0, `vdg_data` = 0, `vdg_valid` = 0, `cpu_rdata` = 0, `cpu_ack` = 0, `vdg_drop` = 0, `wait_cnt` = 0, FSM = IDLE, all tags = NONE.
- Reset mid-operation: in-flight reads are abandoned with no `vdg_valid` or `cpu_ack` after release. A CPU request still held at release is re-arbitrated from IDLE.
- VDG read, sampled at edge E0:
  - `ram_a` = `vdg_addr` after E0.
  - `ram_q` is captured into `vdg_data` at E2.
  - `vdg_valid` is high for the cycle after E2.
  - Latency is 2 clocks, constant.
- CPU write granted at E0: `ram_we` = 1 for exactly one cycle after E0, and `cpu_ack` is high in the same cycle.
- CPU read granted at E0: `cpu_ack` and `cpu_rdata` are valid in the cycle after E2.
- Contention: simultaneous `vdg_req` and `cpu_req` means VDG wins and the CPU grant slips by one cycle. At the legal VDG cadence, CPU grant delay is ≤ 1 cycle and the watchdog never fires.
- `ram_we` is never high in a VDG or NONE slot.

## Test plan
- VDG fetch only: `vdg_req` every 3rd cycle, addresses 0x0000..0x0005, RAM preloaded with addr^0x5A → `vdg_valid` exactly 2 clocks after each request, `vdg_data` = 0x5A, 0x5B, … ; `cpu_wait` = 0.
- CPU write then read: write 0x1FFF ← 0xA5, then read 0x1FFF → `cpu_ack` in the grant cycle for the write; read ack 2 clocks after grant with `cpu_rdata` = 0xA5; `ram_we` pulses once.
- Collision: `cpu_req` (read 0x0100) asserted in the same cycle as `vdg_req` (0x0200) → VDG granted first and returns on time; CPU granted the next cycle and ack 3 clocks after request; `vdg_drop` = 0.
- Watchdog: `vdg_req` held high continuously with `cpu_req` write pending → CPU granted after exactly 4 lost cycles; one VDG request produces no `vdg_valid`; `vdg_drop` = 1 and stays 1.
- Held request: `cpu_req` kept high for one extra cycle after `cpu_ack` → no second RAM access for that request; no duplicate `cpu_ack`.
- Reset mid-read: assert `reset` one cycle after a CPU read grant → all outputs 0 immediately (async); no `cpu_ack` after release; re-asserted request completes normally.
